// File: rtl/lib_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
// rotl1 works on a fixed-width carrier so it can serve any port count up to MAX_PORTS.
package lib_arb_pkg;

  localparam int unsigned MAX_PORTS = 32;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  // Rotate the low n bits of vec left by one; bit n-1 wraps to bit 0.
  function automatic logic [MAX_PORTS-1:0] rotl1(input logic [MAX_PORTS-1:0] vec, input int n);
    logic [MAX_PORTS-1:0] top_bit;
    logic [MAX_PORTS-1:0] res;
    top_bit = MAX_PORTS'(1) << (n - 1);
    res     = ((vec & ~top_bit) << 1) | {{(MAX_PORTS-1){1'b0}}, |(vec & top_bit)};
    return res;
  endfunction

endpackage

// File: rtl/lib_mux_ffs.sv
// Find-first-set from a one-hot base: picks the first request at or above base,
// wrapping to bit 0, and returns it one-hot (zero when no request).
module lib_mux_ffs #(
  parameter int N = 4
) (
  input  logic [N-1:0] base,
  input  logic [N-1:0] req,
  output logic [N-1:0] sel
);

  logic [N-1:0] mask_hi;
  logic [N-1:0] req_hi;
  logic [N-1:0] sel_hi;
  logic [N-1:0] sel_lo;
  logic         acc;
  logic         found_hi;
  logic         found_lo;

  // Thermometer mask of the base and above, then two priority scans: upper half first.
  always_comb begin
    mask_hi  = '0;
    sel_hi   = '0;
    sel_lo   = '0;
    acc      = 1'b0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc        = acc | base[i];
      mask_hi[i] = acc;
    end
    req_hi = req & mask_hi;
    for (int i = 0; i < N; i++) begin
      if (req_hi[i] && !found_hi) begin
        sel_hi[i] = 1'b1;
        found_hi  = 1'b1;
      end
      if (req[i] && !found_lo) begin
        sel_lo[i] = 1'b1;
        found_lo  = 1'b1;
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

endmodule

// File: rtl/lib_rr_arb_mux.sv
// Packet-aware round-robin arbiter steering one of PORTS_NUMBER valid/ready streams
// onto a shared output; the grant can be locked for the length of a packet.
module lib_rr_arb_mux
  import lib_arb_pkg::*;
#(
  parameter int PORTS_NUMBER = 4,
  parameter int WIDTH        = 8,
  parameter int LOCK_PKT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORTS_NUMBER-1:0] req_valid,
  input  logic [PORTS_NUMBER-1:0] req_last,
  input  logic [WIDTH-1:0]        req_data [PORTS_NUMBER],
  output logic [PORTS_NUMBER-1:0] req_ready,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [PORTS_NUMBER-1:0] grant,
  output logic                    busy
);

  arb_state_t              state_q, state_d;
  logic [PORTS_NUMBER-1:0] base_q, base_d;
  logic [PORTS_NUMBER-1:0] grant_q, grant_d;
  logic [PORTS_NUMBER-1:0] ffs_sel;
  logic [WIDTH:0]          mux_out;
  logic                    accept;

  lib_mux_ffs #(.N(PORTS_NUMBER)) u_ffs (
    .base (base_q),
    .req  (req_valid),
    .sel  (ffs_sel)
  );

  // Reset gates the grant, which in turn forces every output low.
  always_comb begin
    grant = '0;
    if (!rst) grant = (state_q == LOCKED) ? grant_q : ffs_sel;
    mux_out = '0;
    for (int i = 0; i < PORTS_NUMBER; i++) begin
      mux_out = mux_out | ({(WIDTH+1){grant[i]}} & {req_last[i], req_data[i]});
    end
    out_last  = mux_out[WIDTH];
    out_data  = mux_out[WIDTH-1:0];
    out_valid = |(req_valid & grant);
    req_ready = grant & {PORTS_NUMBER{out_ready}};
    busy      = (state_q == LOCKED) && !rst;
    accept    = out_valid & out_ready;
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!out_last && (LOCK_PKT != 0)) begin
            state_d = LOCKED;
            grant_d = grant;
          end else begin
            base_d = PORTS_NUMBER'(rotl1(MAX_PORTS'(grant), PORTS_NUMBER));
          end
        end
      end
      LOCKED: begin
        if (accept && out_last) begin
          state_d = IDLE;
          base_d  = PORTS_NUMBER'(rotl1(MAX_PORTS'(grant_q), PORTS_NUMBER));
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= PORTS_NUMBER'(1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      grant_q <= grant_d;
    end
  end

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_ready_subset:  assert property (@(posedge clk) disable iff (rst) (req_ready & ~grant) == '0);
  a_base_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot(base_q));
  a_lock_owner:    assert property (@(posedge clk) disable iff (rst) (state_q == LOCKED) |-> (grant_q != '0));
`endif

endmodule
